// File: rtl/no_clock_frame_seq.sv
// Frame sequencer around a combinational memory datapath: loads a frame word by word,
// lets the datapath settle, captures its outputs in one cycle, then streams them out.
module no_clock_frame_seq #(
    parameter int WIDTH         = 8,
    parameter int DEPTH         = 10,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [WIDTH-1:0]         mem_out [0:DEPTH-1],
    input  logic [WIDTH-1:0]         res_in  [0:DEPTH-1],
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH)-1:0] out_index,
    output logic                     busy,
    output logic                     done,
    output logic [15:0]              frame_count
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        SETTLE = 2'd1,
        UNLOAD = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [IDX_W-1:0]   wr_idx;
    logic [IDX_W-1:0]   rd_idx;
    logic [CNT_W-1:0]   settle_cnt;
    logic [WIDTH-1:0]   result [0:DEPTH-1];

    logic               load_fire;
    logic               load_last;
    logic               capture;
    logic               unload_fire;
    logic               unload_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= LOAD;
        end else begin
            state <= state_next;
        end
    end

    // All outputs decode from registered state/indices so no handshake input leaks through.
    always_comb begin
        state_next  = state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b0;
        load_fire   = 1'b0;
        load_last   = 1'b0;
        capture     = 1'b0;
        unload_fire = 1'b0;
        unload_last = 1'b0;
        out_data    = result[rd_idx];
        out_index   = rd_idx;

        unique case (state)
            LOAD: begin
                in_ready  = 1'b1;
                load_fire = in_valid;
                load_last = in_valid && (wr_idx == LAST_IDX);
                if (load_last) begin
                    state_next = SETTLE;
                end
            end
            SETTLE: begin
                busy    = 1'b1;
                capture = (settle_cnt == '0);
                if (capture) begin
                    state_next = UNLOAD;
                end
            end
            UNLOAD: begin
                busy        = 1'b1;
                out_valid   = 1'b1;
                unload_fire = out_ready;
                unload_last = out_ready && (rd_idx == LAST_IDX);
                if (unload_last) begin
                    state_next = LOAD;
                end
            end
            default: begin
                state_next = LOAD;
            end
        endcase
    end

    // Frame register; it keeps the previous frame until each slot is overwritten.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_idx     <= '0;
            settle_cnt <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_out[i] <= '0;
            end
        end else begin
            if (load_fire) begin
                mem_out[wr_idx] <= in_data;
                if (load_last) begin
                    wr_idx     <= '0;
                    settle_cnt <= SETTLE_LOAD;
                end else begin
                    wr_idx <= wr_idx + IDX_W'(1);
                end
            end else if (state == SETTLE && !capture) begin
                settle_cnt <= settle_cnt - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_idx <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                result[i] <= '0;
            end
        end else begin
            if (capture) begin
                rd_idx <= '0;
                for (int i = 0; i < DEPTH; i++) begin
                    result[i] <= res_in[i];
                end
            end else if (unload_fire) begin
                if (unload_last) begin
                    rd_idx <= '0;
                end else begin
                    rd_idx <= rd_idx + IDX_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            done        <= 1'b0;
            frame_count <= '0;
        end else begin
            done <= unload_last;
            if (unload_last) begin
                frame_count <= frame_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_no_clock_frame_seq.sv
// Scoreboard bench for no_clock_frame_seq; the bench plays the datapath role (result = word + 1).
module tb_no_clock_frame_seq;

    localparam int WIDTH  = 8;
    localparam int DEPTH  = 10;
    localparam int SETTLE = 3;
    localparam int IDX_W  = $clog2(DEPTH);

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic [WIDTH-1:0] data;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [WIDTH-1:0] in_data = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] mem_out [0:DEPTH-1];
    logic [WIDTH-1:0] res_in  [0:DEPTH-1];
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [IDX_W-1:0] out_index;
    logic             busy;
    logic             done;
    logic [15:0]      frame_count;

    logic [WIDTH-1:0] tamper = '0;
    logic [WIDTH-1:0] vec_in  [DEPTH];
    logic [WIDTH-1:0] vec_exp [DEPTH];

    exp_t sb [$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;
    int   cycle = 0;
    int   exp_frames = 0;
    logic done_pend = 1'b0;

    no_clock_frame_seq #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .SETTLE_CYCLES(SETTLE)
    ) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .mem_out(mem_out), .res_in(res_in),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_index(out_index), .busy(busy), .done(done), .frame_count(frame_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle++;

    // Datapath stand-in; tamper disturbs res_in outside the capture cycle.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            res_in[i] = WIDTH'(mem_out[i] + 8'd1) ^ tamper;
        end
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            check_output("done", 32'(done), 32'(done_pend));
            if (done_pend) check_output("frame_count_at_done", 32'(frame_count), 32'(exp_frames));
            done_pend = 1'b0;
            if (out_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_out: got index %0d data %0h with empty scoreboard", out_index, out_data);
                end else begin
                    check_output("out_index", 32'(out_index), 32'(sb[0].idx));
                    check_output("out_data", 32'(out_data), 32'(sb[0].data));
                    if (out_ready) begin
                        mon_e = sb.pop_front();
                        if (mon_e.idx == IDX_W'(DEPTH - 1)) begin
                            done_pend = 1'b1;
                            exp_frames++;
                        end
                    end
                end
            end
        end
    end

    // Feeds vec_in with optional idle cycles before words flagged in gap_mask.
    task automatic apply_stimulus(input logic [DEPTH-1:0] gap_mask, input bit ready_expected,
                                  output int first_cycle, output logic first_done);
        logic acc;
        logic d;
        int   waits;
        first_cycle = 0;
        first_done  = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (gap_mask[i]) begin
                in_valid = 1'b0;
                @(negedge clk);
                if (ready_expected) check_output("in_ready_gap", 32'(in_ready), 32'd1);
                step();
            end
            in_valid = 1'b1;
            in_data  = vec_in[i];
            waits    = 0;
            forever begin
                @(negedge clk);
                acc = in_ready;
                d   = done;
                if (ready_expected) check_output("in_ready_load", 32'(in_ready), 32'd1);
                step();
                if (acc) break;
                waits++;
                if (waits > 60) begin
                    check_output("accept_timeout", 32'(waits), 32'd0);
                    break;
                end
            end
            sb.push_back('{idx: IDX_W'(i), data: vec_exp[i]});
            if (i == 0) begin
                first_cycle = cycle;
                first_done  = d;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic check_settle(input bit check_mem);
        for (int k = 0; k < SETTLE; k++) begin
            @(negedge clk);
            check_output("settle_out_valid", 32'(out_valid), 32'd0);
            check_output("settle_in_ready", 32'(in_ready), 32'd0);
            check_output("settle_busy", 32'(busy), 32'd1);
            if (check_mem && k == SETTLE - 1) begin
                for (int i = 0; i < DEPTH; i++) begin
                    check_output($sformatf("mem_out[%0d]", i), 32'(mem_out[i]), 32'(vec_in[i]));
                end
            end
        end
        @(negedge clk);
        check_output("first_out_valid", 32'(out_valid), 32'd1);
    endtask

    // mode 1 drives out_ready with the repeating 1,0,0 pattern.
    task automatic drain(input int mode, input int remaining);
        int k = 0;
        while (sb.size() > remaining) begin
            step();
            if (sb.size() <= remaining) break;
            k++;
            out_ready = (mode == 1) ? (k % 3 == 0) : 1'b1;
            if (k > 200) begin
                check_output("drain_timeout", 32'(sb.size()), 32'(remaining));
                break;
            end
        end
    endtask

    task automatic check_frame_count(input int exp);
        @(negedge clk);
        check_output("frame_count", 32'(frame_count), 32'(exp));
        step();
    endtask

    task automatic check_reset_state();
        @(negedge clk);
        check_output("rst_in_ready", 32'(in_ready), 32'd1);
        check_output("rst_out_valid", 32'(out_valid), 32'd0);
        check_output("rst_busy", 32'(busy), 32'd0);
        check_output("rst_frame_count", 32'(frame_count), 32'd0);
        check_output("rst_out_index", 32'(out_index), 32'd0);
        check_output("rst_out_data", 32'(out_data), 32'd0);
        for (int i = 0; i < DEPTH; i++) begin
            check_output($sformatf("rst_mem_out[%0d]", i), 32'(mem_out[i]), 32'd0);
        end
        step();
    endtask

    initial begin
        int   fc [3];
        logic fd [3];
        int   dummy_c;
        logic dummy_d;

        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        check_reset_state();

        $display("[TB] reset in the middle of UNLOAD");
        vec_in  = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        vec_exp = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'h3A};
        out_ready = 1'b1;
        apply_stimulus('0, 1'b1, dummy_c, dummy_d);
        check_settle(1'b0);
        drain(0, DEPTH - 4);
        out_ready = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        sb.delete();
        exp_frames = 0;
        check_reset_state();

        $display("[TB] frame of 0..9");
        vec_in  = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09};
        vec_exp = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h0A};
        out_ready = 1'b1;
        apply_stimulus('0, 1'b1, dummy_c, dummy_d);
        check_settle(1'b1);
        drain(0, 0);
        check_frame_count(1);

        $display("[TB] all-0xFF frame wraps to zero");
        vec_in  = '{default: 8'hFF};
        vec_exp = '{default: 8'h00};
        apply_stimulus('0, 1'b1, dummy_c, dummy_d);
        check_settle(1'b1);
        drain(0, 0);
        check_frame_count(2);

        $display("[TB] backpressure on out_ready");
        vec_in  = '{8'h03, 8'h13, 8'h23, 8'h33, 8'h43, 8'h53, 8'h63, 8'h73, 8'h83, 8'h93};
        vec_exp = '{8'h04, 8'h14, 8'h24, 8'h34, 8'h44, 8'h54, 8'h64, 8'h74, 8'h84, 8'h94};
        apply_stimulus('0, 1'b1, dummy_c, dummy_d);
        check_settle(1'b1);
        tamper = 8'h55;
        drain(1, 0);
        out_ready = 1'b1;
        check_frame_count(3);
        tamper = 8'h00;

        $display("[TB] gaps in in_valid");
        vec_in  = '{8'hC3, 8'h7E, 8'h01, 8'h80, 8'hFE, 8'h42, 8'h99, 8'h10, 8'h6D, 8'h2B};
        vec_exp = '{8'hC4, 8'h7F, 8'h02, 8'h81, 8'hFF, 8'h43, 8'h9A, 8'h11, 8'h6E, 8'h2C};
        apply_stimulus(10'b10_1100_1010, 1'b1, dummy_c, dummy_d);
        check_settle(1'b1);
        drain(0, 0);
        check_frame_count(4);

        $display("[TB] three frames back-to-back");
        rst = 1'b1;
        step();
        rst = 1'b0;
        sb.delete();
        exp_frames = 0;
        out_ready = 1'b1;
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < DEPTH; i++) begin
                vec_in[i]  = WIDTH'(8'h40 + 16 * f + i);
                vec_exp[i] = WIDTH'(8'h41 + 16 * f + i);
            end
            apply_stimulus('0, (f == 0), fc[f], fd[f]);
            if (f > 0) begin
                check_output("first_accept_in_done_cycle", 32'(fd[f]), 32'd1);
                check_output("frame_period", 32'(fc[f] - fc[f-1]), 32'd23);
            end
        end
        drain(0, 0);
        check_frame_count(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached at cycle %0d", cycle);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
